// File: rtl/cnt_sweep_ctrl_pkg.sv
// Shared types and constants for the sweep controller slice.
//   WIDTH  : counter / endpoint width
//   PASS_W : pass-count field width
//   state_t, dir_t, cmd_t (sweep command payload), eff_passes()
package cnt_sweep_ctrl_pkg;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned PASS_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_ABRT = 3'd4
  } state_t;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_t;

  typedef struct packed {
    logic [WIDTH-1:0]  start_val;
    logic [WIDTH-1:0]  end_val;
    logic              up;
    logic              pingpong;
    logic [PASS_W-1:0] passes;
  } cmd_t;

  // Single-sweep commands always run one pass; a zero pass count means one.
  function automatic logic [PASS_W-1:0] eff_passes(input logic pingpong,
                                                    input logic [PASS_W-1:0] passes);
    if (!pingpong || passes == '0) return PASS_W'(1);
    return passes;
  endfunction

endpackage

// File: rtl/cnt_sweep_ctrl_if.sv
// Sweep command handshake bus.
//   cmd_valid : command present (master -> slave)
//   cmd       : command payload (master -> slave)
//   cmd_ready : slave can accept (slave -> master)
interface cnt_sweep_ctrl_if import cnt_sweep_ctrl_pkg::*; ();

  logic cmd_valid;
  logic cmd_ready;
  cmd_t cmd;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);

endinterface

// File: rtl/cnt_sweep_ctrl_core.sv
// Loadable up/down counter, wraps modulo 2**WIDTH; load has priority over enable.
//   clk, rst : clock, synchronous active-high reset
//   ld/ld_val: load value
//   en/up    : step enable and direction
//   cnt      : registered count
module updown_cnt_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)     cnt <= '0;
    else if (ld) cnt <= ld_val;
    else if (en) cnt <= up ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
  end

endmodule

// File: rtl/cnt_sweep_ctrl.sv
// Command-driven sweep sequencer around updown_cnt_core.
//   clk, rst  : clock, synchronous active-high reset
//   cmd_if    : command handshake (slave); cmd_ready high only in IDLE
//   pause     : freeze counter and FSM while in RUN
//   abort     : terminate command in LOAD/RUN
//   cnt       : counter value
//   busy      : command in progress (LOAD/RUN)
//   pass_idx  : current pass, 0-based
//   done      : one-cycle pulse on normal completion
//   aborted   : one-cycle pulse on abort completion
module cnt_sweep_ctrl import cnt_sweep_ctrl_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  cnt_sweep_ctrl_if.slave   cmd_if,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  cnt,
  output logic              busy,
  output logic [PASS_W-1:0] pass_idx,
  output logic              done,
  output logic              aborted
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  tgt_q, tgt_d;       // endpoint the current pass runs towards
  logic [WIDTH-1:0]  other_q, other_d;   // opposite endpoint; holds start until first swap
  dir_t              dir_q, dir_d;
  logic [PASS_W-1:0] passes_q, passes_d;
  logic [PASS_W-1:0] pass_idx_d;
  logic              cnt_ld, cnt_en;
  logic              at_tgt, last_pass;

  assign cmd_if.cmd_ready = (state_q == ST_IDLE);
  assign at_tgt           = (cnt == tgt_q);
  assign last_pass        = (pass_idx == passes_q - PASS_W'(1));

  updown_cnt_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .ld     (cnt_ld),
    .ld_val (other_q),
    .en     (cnt_en),
    .up     (dir_q == DIR_UP),
    .cnt    (cnt)
  );

  // State and captured-command registers; status outputs registered from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tgt_q    <= '0;
      other_q  <= '0;
      dir_q    <= DIR_UP;
      passes_q <= PASS_W'(1);
      pass_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      other_q  <= other_d;
      dir_q    <= dir_d;
      passes_q <= passes_d;
      pass_idx <= pass_idx_d;
      busy     <= (state_d == ST_LOAD) || (state_d == ST_RUN);
      done     <= (state_d == ST_DONE);
      aborted  <= (state_d == ST_ABRT);
    end
  end

  // Next-state, datapath control and command bookkeeping.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    other_d    = other_q;
    dir_d      = dir_q;
    passes_d   = passes_q;
    pass_idx_d = pass_idx;
    cnt_ld     = 1'b0;
    cnt_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_if.cmd_valid) begin
          tgt_d    = cmd_if.cmd.end_val;
          other_d  = cmd_if.cmd.start_val;
          dir_d    = cmd_if.cmd.up ? DIR_UP : DIR_DN;
          passes_d = eff_passes(cmd_if.cmd.pingpong, cmd_if.cmd.passes);
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_ABRT;
        end else begin
          cnt_ld     = 1'b1;
          pass_idx_d = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_ABRT;
        end else if (!pause) begin
          if (!at_tgt) begin
            cnt_en = 1'b1;
          end else if (last_pass) begin
            state_d = ST_DONE;
          end else begin
            // Bounce: next pass heads back to the opposite endpoint.
            tgt_d      = other_q;
            other_d    = tgt_q;
            dir_d      = (dir_q == DIR_UP) ? DIR_DN : DIR_UP;
            pass_idx_d = pass_idx + PASS_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ABRT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cnt_sweep_ctrl.sv
// Directed self-checking bench for cnt_sweep_ctrl.
module tb_cnt_sweep_ctrl;
  import cnt_sweep_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              pause;
  logic              abort;
  logic [WIDTH-1:0]  cnt;
  logic              busy;
  logic [PASS_W-1:0] pass_idx;
  logic              done;
  logic              aborted;

  int checks = 0;
  int errors = 0;

  cnt_sweep_ctrl_if cmd_if ();

  cnt_sweep_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_if   (cmd_if),
    .pause    (pause),
    .abort    (abort),
    .cnt      (cnt),
    .busy     (busy),
    .pass_idx (pass_idx),
    .done     (done),
    .aborted  (aborted)
  );

  always #5 clk = ~clk;

  // Present one command for a single edge (assumes controller is idle).
  task automatic issue(input int s, input int e, input bit up, input bit pp, input int np);
    @(negedge clk);
    cmd_if.cmd.start_val = WIDTH'(s);
    cmd_if.cmd.end_val   = WIDTH'(e);
    cmd_if.cmd.up        = up;
    cmd_if.cmd.pingpong  = pp;
    cmd_if.cmd.passes    = PASS_W'(np);
    cmd_if.cmd_valid     = 1'b1;
    @(posedge clk);
    #1 cmd_if.cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cnt !== '0 || busy !== 1'b0 || pass_idx !== '0 || done !== 1'b0 ||
        aborted !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: cnt=%0d busy=%b pass_idx=%0d done=%b aborted=%b ready=%b, need 0 0 0 0 0 1",
               cnt, busy, pass_idx, done, aborted, cmd_if.cmd_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_up_single();
    int ec[8], ed[8], eb[8];
    ec = '{0, 3, 4, 5, 6, 7, 7, 7};
    ed = '{0, 0, 0, 0, 0, 0, 1, 0};
    eb = '{1, 1, 1, 1, 1, 1, 0, 0};
    issue(3, 7, 1'b1, 1'b0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (cnt !== WIDTH'(ec[i]) || done !== 1'(ed[i]) || busy !== 1'(eb[i])) begin
        errors++;
        $display("FAIL up_single s%0d: cnt=%0d done=%b busy=%b, need %0d %0d %0d",
                 i + 1, cnt, done, busy, ec[i], ed[i], eb[i]);
      end
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL up_single ready: got %b need 1", cmd_if.cmd_ready);
    end
  endtask

  task automatic test_down_wrap();
    int ec[8], ed[8];
    ec = '{7, 2, 1, 0, 15, 14, 14, 14};
    ed = '{0, 0, 0, 0, 0, 0, 1, 0};
    issue(2, 14, 1'b0, 1'b0, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (cnt !== WIDTH'(ec[i]) || done !== 1'(ed[i]) || pass_idx !== '0) begin
        errors++;
        $display("FAIL down_wrap s%0d: cnt=%0d done=%b pass_idx=%0d, need %0d %0d 0",
                 i + 1, cnt, done, pass_idx, ec[i], ed[i]);
      end
    end
  endtask

  task automatic test_pingpong();
    int ec[15], ep[15];
    ec = '{14, 0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3, 3, 3};
    ep = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2};
    issue(0, 3, 1'b1, 1'b1, 3);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++;
      if (cnt !== WIDTH'(ec[i]) || pass_idx !== PASS_W'(ep[i]) ||
          done !== (i == 13) || busy !== (i < 13)) begin
        errors++;
        $display("FAIL pingpong s%0d: cnt=%0d pass_idx=%0d done=%b busy=%b, need %0d %0d %0d %0d",
                 i + 1, cnt, pass_idx, done, busy, ec[i], ep[i], (i == 13), (i < 13));
      end
    end
  endtask

  task automatic test_pause();
    int ec[10];
    ec = '{3, 3, 4, 5, 5, 5, 6, 7, 7, 7};
    issue(3, 7, 1'b1, 1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (cnt !== WIDTH'(ec[i]) || done !== (i == 8) || busy !== (i < 8)) begin
        errors++;
        $display("FAIL pause s%0d: cnt=%0d done=%b busy=%b, need %0d %0d %0d",
                 i + 1, cnt, done, busy, ec[i], (i == 8), (i < 8));
      end
      pause = (i == 3) || (i == 4);
    end
    pause = 1'b0;
  endtask

  task automatic test_abort();
    int ec[7], ea[7], eb[7];
    ec = '{7, 3, 4, 4, 4, 4, 4};
    ea = '{0, 0, 0, 1, 0, 0, 0};
    eb = '{1, 1, 1, 0, 0, 0, 0};
    issue(3, 7, 1'b1, 1'b0, 1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (cnt !== WIDTH'(ec[i]) || aborted !== 1'(ea[i]) || busy !== 1'(eb[i]) || done !== 1'b0) begin
        errors++;
        $display("FAIL abort s%0d: cnt=%0d aborted=%b busy=%b done=%b, need %0d %0d %0d 0",
                 i + 1, cnt, aborted, busy, done, ec[i], ea[i], eb[i]);
      end
      if (i == 4) begin
        checks++;
        if (cmd_if.cmd_ready !== 1'b1) begin
          errors++;
          $display("FAIL abort ready: got %b need 1", cmd_if.cmd_ready);
        end
      end
      abort = (i == 2);
    end
    abort = 1'b0;
  endtask

  task automatic test_equal_and_rst();
    issue(9, 9, 1'b1, 1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== (i == 2) || busy !== (i < 2) || (i > 0 && cnt !== WIDTH'(9))) begin
        errors++;
        $display("FAIL equal s%0d: cnt=%0d done=%b busy=%b, need 9 %0d %0d",
                 i + 1, cnt, done, busy, (i == 2), (i < 2));
      end
    end
    issue(0, 15, 1'b1, 1'b0, 1);
    repeat (5) @(negedge clk);
    checks++;
    if (cnt !== WIDTH'(3)) begin
      errors++;
      $display("FAIL midsweep cnt: got %0d need 3", cnt);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (cnt !== '0 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 ||
          pass_idx !== '0 || cmd_if.cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid s%0d: cnt=%0d busy=%b done=%b aborted=%b ready=%b, need 0 0 0 0 1",
                 i, cnt, busy, done, aborted, cmd_if.cmd_ready);
      end
    end
  endtask

  task automatic test_pass_count();
    int ec[4];
    ec = '{0, 5, 6, 6};
    issue(5, 6, 1'b1, 1'b0, 5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (cnt !== WIDTH'(ec[i]) || done !== (i == 3) || (i > 0 && pass_idx !== '0)) begin
        errors++;
        $display("FAIL single_passes s%0d: cnt=%0d done=%b pass_idx=%0d, need %0d %0d 0",
                 i + 1, cnt, done, pass_idx, ec[i], (i == 3));
      end
    end
    ec = '{6, 8, 9, 9};
    issue(8, 9, 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (cnt !== WIDTH'(ec[i]) || done !== (i == 3) || (i > 0 && pass_idx !== '0)) begin
        errors++;
        $display("FAIL zero_passes s%0d: cnt=%0d done=%b pass_idx=%0d, need %0d %0d 0",
                 i + 1, cnt, done, pass_idx, ec[i], (i == 3));
      end
    end
  endtask

  task automatic test_busy_reject();
    int ec[7];
    ec = '{9, 1, 2, 3, 3, 3, 3};
    issue(1, 3, 1'b1, 1'b0, 1);
    cmd_if.cmd.start_val = WIDTH'(10);
    cmd_if.cmd.end_val   = WIDTH'(12);
    cmd_if.cmd_valid     = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (cnt !== WIDTH'(ec[i]) || done !== (i == 4) || cmd_if.cmd_ready !== (i > 4)) begin
        errors++;
        $display("FAIL busy_reject s%0d: cnt=%0d done=%b ready=%b, need %0d %0d %0d",
                 i + 1, cnt, done, cmd_if.cmd_ready, ec[i], (i == 4), (i > 4));
      end
      if (i == 4) cmd_if.cmd_valid = 1'b0;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_reject idle busy: got %b need 0", busy);
    end
  endtask

  initial begin
    rst                  = 1'b1;
    pause                = 1'b0;
    abort                = 1'b0;
    cmd_if.cmd_valid     = 1'b0;
    cmd_if.cmd           = '0;
    test_reset();
    test_up_single();
    test_down_wrap();
    test_pingpong();
    test_pause();
    test_abort();
    test_equal_and_rst();
    test_pass_count();
    test_busy_reject();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
